// File: rtl/gray_counter_if.sv
// gray_counter_if: control inputs and registered count outputs of gray_counter
interface gray_counter_if #(parameter int WIDTH = 4);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] gray;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] toggle;
  logic             wrap;
  modport master (output en, up_dn, load, load_bin, input gray, bin, toggle, wrap);
  modport slave (input en, up_dn, load, load_bin, output gray, bin, toggle, wrap);
endinterface

// File: rtl/gray_counter.sv
// gray_counter: up/down binary count with registered Gray, binary, toggle and wrap outputs
module gray_counter #(parameter int WIDTH = 4) (
  input logic          clk,
  input logic          rst,
  gray_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] one = 1;
  logic [WIDTH-1:0] b, b_n, g_n;
  logic             wrap_n;
  always_comb begin
    b_n    = bus.load ? bus.load_bin : bus.en ? (bus.up_dn ? b + one : b - one) : b;
    wrap_n = !bus.load && bus.en && (bus.up_dn ? &b : ~|b);
    g_n    = b_n ^ (b_n >> 1);
  end
  // hold leaves g_n equal to gray, so toggle clears without a special case
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      b          <= '0;
      bus.gray   <= '0;
      bus.toggle <= '0;
      bus.wrap   <= 1'b0;
    end else begin
      b          <= b_n;
      bus.gray   <= g_n;
      bus.toggle <= g_n ^ bus.gray;
      bus.wrap   <= wrap_n;
    end
  assign bus.bin = b;
endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: table vectors, async reset corner cases and randomized run against a reference model
module tb_gray_counter;
  localparam int W = 4;
  localparam int M = 1 << W;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int m_b = 0;
  int m_g = 0;
  int e_t = 0;
  int e_w = 0;
  gray_counter_if #(.WIDTH(W)) bus ();
  gray_counter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic en, up, ld;
    logic [W-1:0] lb, g, b, t;
    logic w;
  } vec_t;
  vec_t tab [10];
  function automatic int to_gray(int v);
    return v ^ (v / 2);
  endfunction
  function automatic int g2b(logic [W-1:0] g);
    int r = 0;
    for (int i = 0; i < W; i++) if ($countones(g >> i) % 2 == 1) r += 1 << i;
    return r;
  endfunction
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_b = 0; m_g = 0; e_t = 0; e_w = 0;
  endtask
  task automatic cyc(logic en, logic up, logic ld, logic [W-1:0] lb);
    int nb, ng;
    bus.en = en; bus.up_dn = up; bus.load = ld; bus.load_bin = lb;
    nb = ld ? int'(lb) : en ? (up ? (m_b + 1) % M : (m_b + M - 1) % M) : m_b;
    e_w = (!ld && en && ((up && m_b == M - 1) || (!up && m_b == 0))) ? 1 : 0;
    ng = to_gray(nb);
    e_t = ng ^ m_g;
    m_b = nb; m_g = ng;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_model(string tag);
    chk({tag, " gray"}, int'(bus.gray), m_g);
    chk({tag, " bin"}, int'(bus.bin), m_b);
    chk({tag, " toggle"}, int'(bus.toggle), e_t);
    chk({tag, " wrap"}, int'(bus.wrap), e_w);
  endtask
  initial begin
    bus.en = 0; bus.up_dn = 0; bus.load = 0; bus.load_bin = '0;
    tab[0] = '{0, 0, 1, 4'b1001, 4'b1101, 4'b1001, 4'b1101, 0};
    tab[1] = '{0, 0, 1, 4'b1110, 4'b1001, 4'b1110, 4'b0100, 0};
    tab[2] = '{1, 1, 0, 4'b0000, 4'b1000, 4'b1111, 4'b0001, 0};
    tab[3] = '{1, 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 1};
    tab[4] = '{1, 1, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 0};
    tab[5] = '{0, 0, 1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 0};
    tab[6] = '{1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0};
    tab[7] = '{1, 0, 0, 4'b0000, 4'b1000, 4'b1111, 4'b1000, 1};
    tab[8] = '{1, 1, 1, 4'b1100, 4'b1010, 4'b1100, 4'b0010, 0};
    tab[9] = '{0, 1, 0, 4'b0000, 4'b1010, 4'b1100, 4'b0000, 0};
    #2;
    chk_model("reset");
    @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(tab[i].en, tab[i].up, tab[i].ld, tab[i].lb);
      chk($sformatf("vec%0d gray", i), int'(bus.gray), int'(tab[i].g));
      chk($sformatf("vec%0d bin", i), int'(bus.bin), int'(tab[i].b));
      chk($sformatf("vec%0d toggle", i), int'(bus.toggle), int'(tab[i].t));
      chk($sformatf("vec%0d wrap", i), int'(bus.wrap), int'(tab[i].w));
    end
    cyc(0, 0, 0, 4'b0000);
    chk_model("hold2");
    cyc(0, 0, 1, 4'b0101);
    cyc(1, 1, 0, 4'b0000);
    chk("pre-reset bin", int'(bus.bin), 6);
    #3 rst = 1;
    #1;
    model_reset();
    chk_model("async reset");
    @(posedge clk);
    #1 rst = 0;
    cyc(1, 1, 0, 4'b0000);
    chk_model("post-reset up");
    chk("post-reset up bin", int'(bus.bin), 1);
    rst = 1;
    #2 rst = 0;
    model_reset();
    cyc(1, 0, 0, 4'b0000);
    chk_model("post-reset down");
    chk("post-reset down bin", int'(bus.bin), M - 1);
    for (int i = 0; i < 80; i++) begin
      logic ld, en;
      ld = ($urandom % 10) == 0;
      en = ($urandom % 8) != 0;
      cyc(en, 1'($urandom), ld, W'($urandom));
      chk_model($sformatf("rand%0d", i));
      chk($sformatf("rand%0d g2b", i), g2b(bus.gray), int'(bus.bin));
      if (en && !ld) chk($sformatf("rand%0d onehot", i), $countones(bus.toggle), 1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
